// File: rtl/c2h_pkg.sv
// Shared definitions for the C2H capture scheduler.
//   c2h_sched_state_t : scheduler FSM states
//   SCHED_PERIOD_W    : width of the capture period / period timer
//   SCHED_CNT_W       : width of packet and overrun counters
//   SCHED_CRED_W      : width of the outstanding-completion counter
//   sched_reload_val  : timer reload value for a given period (0 behaves as 1)
package c2h_pkg;

   localparam int SCHED_PERIOD_W = 32;
   localparam int SCHED_CNT_W    = 16;
   localparam int SCHED_CRED_W   = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_ISSUE,
      ST_IN_FLIGHT,
      ST_DRAIN,
      ST_DONE
   } c2h_sched_state_t;

   function automatic logic [SCHED_PERIOD_W-1:0] sched_reload_val(
      input logic [SCHED_PERIOD_W-1:0] period
   );
      return (period == '0) ? '0 : period - SCHED_PERIOD_W'(1);
   endfunction

endpackage

// File: rtl/c2h_sched_timer.sv
// Period down-counter for the capture scheduler.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val this cycle (wins over counting)
//   load_val   : value to load
//   value      : current count; decrements each cycle while nonzero, holds at 0
//   zero       : value == 0
module c2h_sched_timer
   import c2h_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic [SCHED_PERIOD_W-1:0] load_val,
   output logic [SCHED_PERIOD_W-1:0] value,
   output logic                      zero
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (value != '0) begin
         value <= value - SCHED_PERIOD_W'(1);
      end
   end

   assign zero = (value == '0);

endmodule

// File: rtl/c2h_capture_sched.sv
// Capture scheduler for a C2H streaming engine. Issues one-cycle capture
// pulses no faster than cfg_period apart, never while a packet is in flight,
// and only while fewer than cfg_max_outstanding completions are pending.
//   clk, rst_n            : clock, synchronous active-low reset
//   start, abort          : one-cycle run control pulses
//   cfg_period            : minimum cycles between capture pulses (0 -> 1)
//   cfg_pkt_count         : packets per run (0 -> unbounded)
//   cfg_max_outstanding   : completion credit limit (0 -> 1)
//   c2h_tvalid/tready/tlast, c2h_cmpt_tvalid/tready : observed handshakes
//   ctrl_c2h_capture      : capture pulse to the C2H engine
//   busy, done            : run status / end-of-run pulse
//   pkts_sent, overruns   : per-run packet count and saturating overrun count
module c2h_capture_sched
   import c2h_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [SCHED_PERIOD_W-1:0] cfg_period,
   input  logic [SCHED_CNT_W-1:0]    cfg_pkt_count,
   input  logic [3:0]                cfg_max_outstanding,
   input  logic                      c2h_tvalid,
   input  logic                      c2h_tready,
   input  logic                      c2h_tlast,
   input  logic                      c2h_cmpt_tvalid,
   input  logic                      c2h_cmpt_tready,
   output logic                      ctrl_c2h_capture,
   output logic                      busy,
   output logic                      done,
   output logic [SCHED_CNT_W-1:0]    pkts_sent,
   output logic [SCHED_CNT_W-1:0]    overruns
);

   c2h_sched_state_t          state, state_nxt;
   logic [SCHED_CRED_W-1:0]   outstanding;
   logic [SCHED_CRED_W-1:0]   max_eff;
   logic                      abort_lat;
   logic                      tmr_load;
   logic [SCHED_PERIOD_W-1:0] tmr_load_val;
   logic [SCHED_PERIOD_W-1:0] tmr_value;
   logic                      tmr_zero;
   logic                      credit_ok;
   logic                      pkt_end;
   logic                      cmpt_hs;
   logic [SCHED_CNT_W-1:0]    pkts_inc;
   logic                      count_reached;
   logic                      overrun_evt;

   assign max_eff       = (cfg_max_outstanding == 4'd0) ? SCHED_CRED_W'(1)
                                                        : SCHED_CRED_W'(cfg_max_outstanding);
   assign credit_ok     = (outstanding < max_eff);
   assign pkt_end       = c2h_tvalid & c2h_tready & c2h_tlast;
   assign cmpt_hs       = c2h_cmpt_tvalid & c2h_cmpt_tready;
   assign pkts_inc      = pkts_sent + SCHED_CNT_W'(1);
   assign count_reached = (cfg_pkt_count != '0) && (pkts_inc >= cfg_pkt_count);

   // A missed period: the timer expires while we cannot issue, either because
   // a packet is still streaming or because we are starved of credits.
   assign overrun_evt = (tmr_value == SCHED_PERIOD_W'(1)) &&
                        ((state == ST_IN_FLIGHT) || ((state == ST_ARM) && !credit_ok));

   c2h_sched_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .value    (tmr_value),
      .zero     (tmr_zero)
   );

   // The timer is reloaded on the ARM->ISSUE edge so that it already reads
   // period-1 during the capture cycle; successive pulses are then exactly
   // cfg_period apart when nothing else stalls the run.
   always_comb begin
      state_nxt    = state;
      tmr_load     = 1'b0;
      tmr_load_val = sched_reload_val(cfg_period);
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt    = ST_ARM;
               tmr_load     = 1'b1;
               tmr_load_val = '0;
            end
         end
         ST_ARM: begin
            if (abort) begin
               state_nxt = ST_DRAIN;
            end else if (tmr_zero && credit_ok) begin
               state_nxt = ST_ISSUE;
               tmr_load  = 1'b1;
            end
         end
         ST_ISSUE:     state_nxt = ST_IN_FLIGHT;
         ST_IN_FLIGHT: begin
            if (pkt_end) begin
               state_nxt = (abort_lat || abort || count_reached) ? ST_DRAIN : ST_ARM;
            end
         end
         ST_DRAIN: begin
            if (outstanding == '0) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign ctrl_c2h_capture = (state == ST_ISSUE);
   assign busy             = (state != ST_IDLE);
   assign done             = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         outstanding <= '0;
         abort_lat   <= 1'b0;
         pkts_sent   <= '0;
         overruns    <= '0;
      end else begin
         state <= state_nxt;

         // Simultaneous capture and completion cancel; the counter never wraps.
         if (ctrl_c2h_capture && !cmpt_hs && (outstanding != {SCHED_CRED_W{1'b1}})) begin
            outstanding <= outstanding + SCHED_CRED_W'(1);
         end else if (cmpt_hs && !ctrl_c2h_capture && (outstanding != '0)) begin
            outstanding <= outstanding - SCHED_CRED_W'(1);
         end

         if ((state == ST_IDLE) && start) begin
            abort_lat <= 1'b0;
            pkts_sent <= '0;
            overruns  <= '0;
         end else begin
            if (((state == ST_ISSUE) || (state == ST_IN_FLIGHT)) && abort) begin
               abort_lat <= 1'b1;
            end
            if ((state == ST_IN_FLIGHT) && pkt_end) begin
               pkts_sent <= pkts_inc;
            end
            if (overrun_evt && (overruns != {SCHED_CNT_W{1'b1}})) begin
               overruns <= overruns + SCHED_CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_c2h_capture_sched.sv
// Testbench for c2h_capture_sched: a C2H engine emulator drives packet and
// completion traffic in response to capture pulses, a behavioural model
// predicts every output cycle by cycle, and directed scenarios pin the model
// with hand-derived expectations.
module tb_c2h_capture_sched;

   logic        clk = 1'b0;
   logic        rst_n, start, abort;
   logic [31:0] cfg_period;
   logic [15:0] cfg_pkt_count;
   logic [3:0]  cfg_max_outstanding;
   logic        c2h_tvalid, c2h_tready, c2h_tlast, c2h_cmpt_tvalid, c2h_cmpt_tready;
   logic        ctrl_c2h_capture, busy, done;
   logic [15:0] pkts_sent, overruns;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   c2h_capture_sched dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .start               (start),
      .abort               (abort),
      .cfg_period          (cfg_period),
      .cfg_pkt_count       (cfg_pkt_count),
      .cfg_max_outstanding (cfg_max_outstanding),
      .c2h_tvalid          (c2h_tvalid),
      .c2h_tready          (c2h_tready),
      .c2h_tlast           (c2h_tlast),
      .c2h_cmpt_tvalid     (c2h_cmpt_tvalid),
      .c2h_cmpt_tready     (c2h_cmpt_tready),
      .ctrl_c2h_capture    (ctrl_c2h_capture),
      .busy                (busy),
      .done                (done),
      .pkts_sent           (pkts_sent),
      .overruns            (overruns)
   );

   // traffic knobs
   int beats_per_pkt   = 16;
   int tready_mode     = 0;   // 0: always ready, 1: random
   int cmpt_mode       = 0;   // 0: always ready, 1: random, 2: held off until cmpt_hold_until
   int cmpt_hold_until = 0;

   int cyc = 0;
   bit m_rst_seen = 1'b1;

   // event records
   int cap_cyc[$];
   int done_cnt       = 0;
   int done_cyc       = -1;
   int first_cmpt_cyc = -1;
   int last_cmpt_cyc  = -1;

   // engine emulator state
   bit eng_open   = 1'b0;
   int eng_queued = 0;
   int eng_beat   = 0;
   int eng_pkt_no = 0;
   int cmpt_q     = 0;

   task automatic check(input string name, input longint got, input longint want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL cyc=%0d %s: got %0d, want %0d", cyc, name, got, want);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Run described by phase flags and a timer deadline: the period timer reads
   // max(0, m_deadline - cycle).
   bit m_valid = 1'b0;
   bit m_active, m_cap, m_pkt_open, m_stopping, m_done, m_abort_req;
   int m_pkts, m_ovr, m_outst, m_deadline;

   initial begin : model
      int  per, mx, tmr, n_out;
      bit  arm, tl, ch;
      forever begin
         @(posedge clk);
         m_rst_seen = (rst_n !== 1'b1);
         if (rst_n !== 1'b1) begin
            m_active = 0; m_cap = 0; m_pkt_open = 0; m_stopping = 0; m_done = 0;
            m_abort_req = 0; m_pkts = 0; m_ovr = 0; m_outst = 0;
            m_deadline = cyc + 1;
            m_valid = 1'b1;
         end else if (m_valid) begin
            per = (cfg_period == 0) ? 1 : int'(cfg_period);
            mx  = (cfg_max_outstanding == 0) ? 1 : int'(cfg_max_outstanding);
            tmr = (m_deadline > cyc) ? (m_deadline - cyc) : 0;
            arm = m_active && !m_cap && !m_pkt_open && !m_stopping && !m_done;
            tl  = c2h_tvalid && c2h_tready && c2h_tlast;
            ch  = c2h_cmpt_tvalid && c2h_cmpt_tready;
            if (ch) begin
               if (first_cmpt_cyc < 0) first_cmpt_cyc = cyc;
               last_cmpt_cyc = cyc;
            end
            if (tmr == 1 && (m_pkt_open || (arm && m_outst >= mx)) && m_ovr < 65535)
               m_ovr++;
            n_out = m_outst;
            if (m_cap && !ch && m_outst < 31) n_out = m_outst + 1;
            if (ch && !m_cap && m_outst > 0)  n_out = m_outst - 1;
            if (!m_active) begin
               if (start) begin
                  m_active = 1; m_pkts = 0; m_ovr = 0; m_abort_req = 0;
                  m_deadline = cyc + 1;
               end
            end else if (m_cap) begin
               m_cap = 0; m_pkt_open = 1;
               if (abort) m_abort_req = 1;
            end else if (m_pkt_open) begin
               if (abort) m_abort_req = 1;
               if (tl) begin
                  m_pkts = (m_pkts + 1) % 65536;
                  m_pkt_open = 0;
                  if (m_abort_req || (cfg_pkt_count != 0 && m_pkts >= int'(cfg_pkt_count)))
                     m_stopping = 1;
               end
            end else if (m_stopping) begin
               if (m_outst == 0) begin m_stopping = 0; m_done = 1; end
            end else if (m_done) begin
               m_done = 0; m_active = 0;
            end else begin
               if (abort) m_stopping = 1;
               else if (tmr == 0 && m_outst < mx) begin
                  m_cap = 1;
                  m_deadline = cyc + per;
               end
            end
            m_outst = n_out;
         end
         cyc++;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin : compare
      forever begin
         @(negedge clk);
         if (m_valid) begin
            check("capture",   longint'(ctrl_c2h_capture), longint'(m_cap));
            check("busy",      longint'(busy),             longint'(m_active));
            check("done",      longint'(done),             longint'(m_done));
            check("pkts_sent", longint'(pkts_sent),        longint'(m_pkts));
            check("overruns",  longint'(overruns),         longint'(m_ovr));
         end
         if (ctrl_c2h_capture === 1'b1) cap_cyc.push_back(cyc);
         if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      end
   end

   // ---------------- C2H engine emulator ----------------
   initial begin : engine
      c2h_tvalid = 0; c2h_tready = 0; c2h_tlast = 0;
      c2h_cmpt_tvalid = 0; c2h_cmpt_tready = 0;
      forever begin
         @(negedge clk);
         if (m_rst_seen) begin
            eng_open = 0; eng_queued = 0; eng_beat = 0; cmpt_q = 0;
         end else begin
            if (c2h_tvalid && c2h_tready) begin
               if (c2h_tlast) begin eng_open = 0; cmpt_q++; end
               else eng_beat++;
            end
            if (c2h_cmpt_tvalid && c2h_cmpt_tready && cmpt_q > 0) cmpt_q--;
            if (ctrl_c2h_capture) begin
               n_cmp++;
               if (eng_open) begin
                  n_bad++;
                  $display("FAIL cyc=%0d capture_mid_packet: capture at open beat %0d, want no open packet",
                           cyc, eng_beat);
               end
            end
            if (!eng_open && eng_queued > 0) begin
               eng_open = 1; eng_queued--; eng_beat = 0; eng_pkt_no++;
            end
            if (ctrl_c2h_capture) eng_queued++;
         end
         c2h_tvalid = eng_open;
         c2h_tlast  = eng_open && (eng_beat == beats_per_pkt - 1);
         c2h_tready = (tready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         c2h_cmpt_tvalid = (cmpt_q > 0);
         case (cmpt_mode)
            0:       c2h_cmpt_tready = 1'b1;
            1:       c2h_cmpt_tready = 1'($urandom_range(0, 1));
            default: c2h_cmpt_tready = (cyc >= cmpt_hold_until);
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_stats();
      cap_cyc.delete();
      done_cnt = 0; done_cyc = -1; first_cmpt_cyc = -1; last_cmpt_cyc = -1;
   endtask

   task automatic set_cfg(input int per, input int cnt, input int mx, input int beats);
      cfg_period = 32'(per); cfg_pkt_count = 16'(cnt); cfg_max_outstanding = 4'(mx);
      beats_per_pkt = beats;
   endtask

   task automatic pulse_start(output int s);
      start = 1; s = cyc; tick(); start = 0;
   endtask

   task automatic pulse_abort();
      abort = 1; tick(); abort = 0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin tick(); n++; end
      if (busy !== 1'b0) check({name, "_timeout"}, 1, 0);
      repeat (3) tick();
   endtask

   initial begin : stim
      int s, p0;
      bit ok;
      rst_n = 0; start = 0; abort = 0;
      set_cfg(0, 0, 4, 16);
      repeat (3) tick();
      check("rst_busy",    busy, 0);
      check("rst_capture", ctrl_c2h_capture, 0);
      check("rst_done",    done, 0);
      check("rst_pkts",    pkts_sent, 0);
      check("rst_ovr",     overruns, 0);
      rst_n = 1;
      repeat (2) tick();

      // three back-to-back packets, no period limit
      set_cfg(0, 3, 4, 16); tready_mode = 0; cmpt_mode = 0;
      clear_stats(); pulse_start(s);
      wait_idle("basic", 2000);
      check("basic_caps",  cap_cyc.size(), 3);
      check("basic_first", (cap_cyc.size() > 0) ? cap_cyc[0] - s : -1, 2);
      check("basic_pkts",  pkts_sent, 3);
      check("basic_dones", done_cnt, 1);
      check("basic_ovr",   overruns, 0);

      // period 100: pulses at start+2 and start+102
      set_cfg(100, 2, 4, 16);
      clear_stats(); pulse_start(s);
      wait_idle("period", 2000);
      check("period_caps",   cap_cyc.size(), 2);
      check("period_cap0",   (cap_cyc.size() > 0) ? cap_cyc[0] - s : -1, 2);
      check("period_cap1",   (cap_cyc.size() > 1) ? cap_cyc[1] - s : -1, 102);
      check("period_done_after_cmpt", longint'(done_cyc > last_cmpt_cyc && last_cmpt_cyc >= 0), 1);
      check("period_ovr",    overruns, 0);

      // short period with back-pressure: overruns accumulate
      set_cfg(4, 0, 4, 16); tready_mode = 1; cmpt_mode = 1;
      clear_stats(); pulse_start(s);
      repeat (400) tick();
      pulse_abort();
      wait_idle("overrun", 2000);
      check("overrun_grew", longint'(overruns > 0), 1);
      check("overrun_dones", done_cnt, 1);

      // single credit, completions held off for 200 cycles
      set_cfg(0, 2, 1, 4); tready_mode = 0; cmpt_mode = 2;
      cmpt_hold_until = cyc + 201;
      clear_stats(); pulse_start(s);
      repeat (150) tick();
      check("credit_caps_held", cap_cyc.size(), 1);
      wait_idle("credit", 2000);
      check("credit_caps", cap_cyc.size(), 2);
      check("credit_second_after_cmpt",
            longint'((cap_cyc.size() > 1) && first_cmpt_cyc >= 0 && cap_cyc[1] > first_cmpt_cyc), 1);
      cmpt_mode = 0;

      // abort on beat 5 of packet 2
      set_cfg(0, 0, 4, 8);
      clear_stats(); p0 = eng_pkt_no; pulse_start(s);
      ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
         tick();
         if (eng_pkt_no == p0 + 2 && eng_open && eng_beat == 4) ok = 1;
      end
      check("abort_point_reached", ok, 1);
      pulse_abort();
      wait_idle("abort", 1000);
      check("abort_caps",  cap_cyc.size(), 2);
      check("abort_pkts",  pkts_sent, 2);
      check("abort_dones", done_cnt, 1);

      // start and abort together in IDLE: start wins
      set_cfg(0, 1, 4, 4);
      clear_stats();
      start = 1; abort = 1; s = cyc; tick(); start = 0; abort = 0;
      check("startabort_busy", busy, 1);
      wait_idle("startabort", 500);
      check("startabort_pkts", pkts_sent, 1);

      // reset mid-packet, then a fresh run
      set_cfg(0, 0, 4, 16);
      clear_stats(); pulse_start(s);
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick();
         if (eng_open && eng_beat == 6) ok = 1;
      end
      check("midrst_point_reached", ok, 1);
      rst_n = 0; tick(); rst_n = 1;
      check("midrst_busy", busy, 0);
      check("midrst_cap",  ctrl_c2h_capture, 0);
      check("midrst_pkts", pkts_sent, 0);
      check("midrst_ovr",  overruns, 0);
      check("midrst_no_done", done_cnt, 0);
      tick();
      set_cfg(0, 1, 4, 16);
      clear_stats(); pulse_start(s);
      check("midrst_new_pkts", pkts_sent, 0);
      wait_idle("midrst_new", 1000);
      check("midrst_new_final", pkts_sent, 1);

      // randomized runs, model-checked every cycle
      for (int r = 0; r < 10; r++) begin
         int cnt;
         cnt = int'($urandom_range(0, 4));
         set_cfg(int'($urandom_range(0, 12)), cnt, int'($urandom_range(0, 3)),
                 int'($urandom_range(1, 6)));
         tready_mode = int'($urandom_range(0, 1));
         cmpt_mode   = int'($urandom_range(0, 1));
         clear_stats(); pulse_start(s);
         repeat ($urandom_range(1, 10)) tick();
         pulse_start(p0);
         if (cnt == 0 || $urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(5, 120)) tick();
            pulse_abort();
         end
         wait_idle("rand", 3000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #(600000);
      $display("FAIL watchdog: simulation exceeded cycle budget, got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
